vga_plot_arbiter: RTL and testbench
===================================

Name: vga_plot_arbiter

Overview:
Shares the single pixel-write port of the VGA adapter (vga_x/vga_y/vga_colour/vga_plot) between two independent drawing requesters and a built-in full-screen clear engine. It sits between the drawing FSMs and the VGA adapter instance in the top level. It issues at most one plot per clock. Requester arbitration is round-robin; a clear sweep owns the port exclusively.

Parameters:
SCREEN_W, 160, horizontal resolution; valid x is 0..SCREEN_W-1
SCREEN_H, 120, vertical resolution; valid y is 0..SCREEN_H-1

Ports:
clk  in  1  system clock (CLOCK_50 domain)
rst_n  in  1  asynchronous active-low reset
clear_start  in  1  single-cycle pulse; requests a full-screen fill
clear_colour  in  3  fill colour, sampled on the accepted clear_start
req0  in  1  requester 0 has a pixel pending
x0  in  8  requester 0 x coordinate
y0  in  7  requester 0 y coordinate
c0  in  3  requester 0 colour
gnt0  out  1  requester 0 pixel accepted this cycle (combinational)
req1, x1, y1, c1  in  1/8/7/3  requester 1, same meaning as requester 0
gnt1  out  1  requester 1 pixel accepted this cycle (combinational)
busy  out  1  high while a clear sweep is in progress
clear_done  out  1  one-cycle pulse after the last clear pixel is issued
vga_x  out  8  to VGA adapter
vga_y  out  7  to VGA adapter
vga_colour  out  3  to VGA adapter
vga_plot  out  1  to VGA adapter, write strobe

Behaviour:
- Reset (async, rst_n=0): state=ARB; vga_x=0, vga_y=0, vga_colour=0, vga_plot=0, busy=0, clear_done=0; RR pointer last=1, so requester 0 wins the first tie.
- States: ARB, CLEAR.
- ARB:
  - clear_start=1 -> go to CLEAR. gnt0=gnt1=0 this cycle; clear has priority over pending requests.
  - Else, exactly one requesting req -> its gnt=1.
  - Else, both requesting -> grant the one != last; last updated to the granted index.
- Handshake: a requester holds req and its x/y/c stable until it samples its gnt high at a rising edge. One gnt transfers one pixel. It may deassert req or present a new pixel the next cycle. Back-to-back grants to the same requester are allowed when the other is idle.
- Output latency: a pixel granted in cycle T appears on vga_x/y/colour with vga_plot=1 during cycle T+1 (registered). vga_plot=0 in any cycle following a cycle with no grant or clear pixel.
- Out-of-range coordinates (x>=SCREEN_W or y>=SCREEN_H): the pixel is still granted but dropped. vga_plot=0 for that slot; vga_x/y hold their previous values.
- CLEAR:
  - busy=1 from the cycle after the accepted clear_start.
  - Internal counters cx (8b) and cy (7b) start at 0,0. One pixel is issued per cycle with vga_plot=1 and vga_colour=clear_colour (latched).
  - Order: x inner loop 0..SCREEN_W-1, y outer loop 0..SCREEN_H-1. Total SCREEN_W*SCREEN_H plot cycles (19200 at defaults), contiguous.
  - gnt0=gnt1=0 throughout; clear_start is ignored.
  - After the pixel (SCREEN_W-1, SCREEN_H-1) is latched: clear_done=1 for one cycle, busy=0, return to ARB. Requesters may be granted in the same cycle clear_done is high.
- Counter wrap: cx wraps to 0 and cy increments when cx=SCREEN_W-1. No counter ever reaches SCREEN_W/SCREEN_H on the output.
- Reset mid-sweep: sweep aborted immediately; no clear_done; outputs go to reset values; RR pointer reset.
- The RR pointer is unchanged by clears and by single-requester grants to the same index.

Test Plan:
- Reset, then req0=1 with (10,20,3) and req1=0 -> gnt0=1 the same cycle; next cycle vga_plot=1, vga_x=10, vga_y=20, vga_colour=3; following cycle vga_plot=0.
- req0 and req1 held high for 4 cycles -> grant order 0,1,0,1; vga_plot=1 for 4 consecutive cycles with matching coordinates.
- req0=1 with x=160, y=5 -> gnt0=1; vga_plot stays 0 next cycle.
- clear_start with clear_colour=5 while req1=1 -> gnt1=0 for all 19200 plot cycles. The checker sees every (x,y) in 0..159 x 0..119 exactly once, x-major, colour 5. Then clear_done pulses once, busy falls, and gnt1=1 that cycle.
- Second clear_start pulsed mid-sweep -> ignored; total plots still 19200; a single clear_done.
- rst_n=0 at sweep pixel 5000 -> vga_plot=0 and busy=0 immediately; no clear_done; after release req0 is granted normally.

Source files
------------

// File: rtl/vga_plot_arbiter.sv
// vga_plot_arbiter
// Shares the single pixel-write port of the VGA adapter between two drawing
// requesters (round-robin) and a built-in full-screen clear engine.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   clear_start           one-cycle pulse requesting a full-screen fill
//   clear_colour          fill colour, captured when clear_start is accepted
//   req0/x0/y0/c0, gnt0   requester 0 pixel request and same-cycle grant
//   req1/x1/y1/c1, gnt1   requester 1 pixel request and same-cycle grant
//   busy                  high while a clear sweep is running
//   clear_done            one-cycle pulse once the last clear pixel is latched
//   vga_x/vga_y/vga_colour/vga_plot   registered pixel write to the adapter
module vga_plot_arbiter #(
    parameter int unsigned SCREEN_W = 160,
    parameter int unsigned SCREEN_H = 120
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear_start,
    input  logic [2:0] clear_colour,
    input  logic       req0,
    input  logic [7:0] x0,
    input  logic [6:0] y0,
    input  logic [2:0] c0,
    output logic       gnt0,
    input  logic       req1,
    input  logic [7:0] x1,
    input  logic [6:0] y1,
    input  logic [2:0] c1,
    output logic       gnt1,
    output logic       busy,
    output logic       clear_done,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot
);

    localparam logic ST_ARB   = 1'b0;
    localparam logic ST_CLEAR = 1'b1;

    localparam logic [8:0] X_LIM  = 9'(SCREEN_W);
    localparam logic [7:0] Y_LIM  = 8'(SCREEN_H);
    localparam logic [7:0] X_LAST = 8'(SCREEN_W - 1);
    localparam logic [6:0] Y_LAST = 7'(SCREEN_H - 1);

    logic       state;
    logic       last;     // index of the most recently granted requester
    logic [7:0] cx;
    logic [6:0] cy;
    logic [2:0] clr_col;

    logic [7:0] pick_x;
    logic [6:0] pick_y;
    logic [2:0] pick_c;
    logic       in_range;

    // Grants are combinational so a requester sees acceptance in the same cycle.
    // A pending clear_start pre-empts both requesters.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state == ST_ARB && !clear_start) begin
            if (req0 && req1) begin
                if (last) gnt0 = 1'b1;
                else      gnt1 = 1'b1;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    always_comb begin
        pick_x   = gnt1 ? x1 : x0;
        pick_y   = gnt1 ? y1 : y0;
        pick_c   = gnt1 ? c1 : c0;
        in_range = ({1'b0, pick_x} < X_LIM) && ({1'b0, pick_y} < Y_LIM);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_ARB;
            last       <= 1'b1;
            cx         <= 8'd0;
            cy         <= 7'd0;
            clr_col    <= 3'd0;
            busy       <= 1'b0;
            clear_done <= 1'b0;
            vga_x      <= 8'd0;
            vga_y      <= 7'd0;
            vga_colour <= 3'd0;
            vga_plot   <= 1'b0;
        end else begin
            vga_plot   <= 1'b0;
            clear_done <= 1'b0;
            case (state)
                ST_ARB: begin
                    if (clear_start) begin
                        state   <= ST_CLEAR;
                        busy    <= 1'b1;
                        cx      <= 8'd0;
                        cy      <= 7'd0;
                        clr_col <= clear_colour;
                    end else if (gnt0 || gnt1) begin
                        last <= gnt1;
                        // Out-of-range pixels are consumed but never reach the adapter.
                        if (in_range) begin
                            vga_plot   <= 1'b1;
                            vga_x      <= pick_x;
                            vga_y      <= pick_y;
                            vga_colour <= pick_c;
                        end
                    end
                end
                ST_CLEAR: begin
                    vga_plot   <= 1'b1;
                    vga_x      <= cx;
                    vga_y      <= cy;
                    vga_colour <= clr_col;
                    if (cx == X_LAST) begin
                        cx <= 8'd0;
                        if (cy == Y_LAST) begin
                            state      <= ST_ARB;
                            busy       <= 1'b0;
                            clear_done <= 1'b1;
                        end else begin
                            cy <= cy + 7'd1;
                        end
                    end else begin
                        cx <= cx + 8'd1;
                    end
                end
                default: state <= ST_ARB;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Randomised self-checking bench for vga_plot_arbiter. A pixel-level reference
// model tracks the arbiter's observable behaviour: clear sweep position is a
// linear pixel index n, with (x, y) = (n % W, n / W).
module tb_vga_plot_arbiter;

    localparam int W    = 160;
    localparam int H    = 120;
    localparam int NPIX = W * H;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear_start;
    logic [2:0] clear_colour;
    logic       req0, req1;
    logic [7:0] x0, x1;
    logic [6:0] y0, y1;
    logic [2:0] c0, c1;
    logic       gnt0, gnt1, busy, clear_done, vga_plot;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;

    vga_plot_arbiter #(.SCREEN_W(W), .SCREEN_H(H)) dut (
        .clk(clk), .rst_n(rst_n),
        .clear_start(clear_start), .clear_colour(clear_colour),
        .req0(req0), .x0(x0), .y0(y0), .c0(c0), .gnt0(gnt0),
        .req1(req1), .x1(x1), .y1(y1), .c1(c1), .gnt1(gnt1),
        .busy(busy), .clear_done(clear_done),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model state
    bit   m_clearing;
    int   m_n;
    int   m_last;
    int   m_col;
    int   e_plot, e_x, e_y, e_c, e_busy, e_done;
    bit   eg0, eg1;
    int   dut_plots, dut_dones, dut_g1;

    task automatic model_reset();
        m_clearing = 0; m_n = 0; m_last = 1; m_col = 0;
        e_plot = 0; e_x = 0; e_y = 0; e_c = 0; e_busy = 0; e_done = 0;
    endtask

    // One clock: check at negedge with stable inputs, advance model at posedge.
    task automatic step(input string tag);
        int winner, n_plot, n_x, n_y, n_c, n_done;
        @(negedge clk);
        winner = -1;
        if (!m_clearing && !clear_start) begin
            if (req0 && req1) winner = 1 - m_last;
            else if (req0)    winner = 0;
            else if (req1)    winner = 1;
        end
        eg0 = (winner == 0);
        eg1 = (winner == 1);
        check_val({tag, ".gnt0"}, {31'b0, gnt0}, {31'b0, eg0});
        check_val({tag, ".gnt1"}, {31'b0, gnt1}, {31'b0, eg1});
        check_val({tag, ".plot"}, {31'b0, vga_plot}, e_plot);
        check_val({tag, ".x"}, {24'b0, vga_x}, e_x);
        check_val({tag, ".y"}, {25'b0, vga_y}, e_y);
        if (e_plot == 1) check_val({tag, ".colour"}, {29'b0, vga_colour}, e_c);
        check_val({tag, ".busy"}, {31'b0, busy}, e_busy);
        check_val({tag, ".done"}, {31'b0, clear_done}, e_done);
        if (vga_plot === 1'b1)   dut_plots++;
        if (clear_done === 1'b1) dut_dones++;
        if (gnt1 === 1'b1)       dut_g1++;

        n_plot = 0; n_done = 0; n_x = e_x; n_y = e_y; n_c = e_c;
        if (m_clearing) begin
            n_plot = 1; n_x = m_n % W; n_y = m_n / W; n_c = m_col;
            m_n++;
            if (m_n == NPIX) begin
                m_clearing = 0;
                n_done = 1;
            end
        end else if (clear_start) begin
            m_clearing = 1; m_n = 0; m_col = int'(clear_colour);
        end else if (winner >= 0) begin
            int px, py, pc;
            px = (winner == 0) ? int'(x0) : int'(x1);
            py = (winner == 0) ? int'(y0) : int'(y1);
            pc = (winner == 0) ? int'(c0) : int'(c1);
            m_last = winner;
            if (px < W && py < H) begin
                n_plot = 1; n_x = px; n_y = py; n_c = pc;
            end
        end
        @(posedge clk);
        e_plot = n_plot; e_x = n_x; e_y = n_y; e_c = n_c; e_done = n_done;
        e_busy = m_clearing ? 1 : 0;
        #1;
    endtask

    task automatic new_pixel(output logic [7:0] x, output logic [6:0] y, output logic [2:0] c);
        x = 8'($urandom_range(0, W + 10));
        y = 7'($urandom_range(0, 127));
        c = 3'($urandom_range(0, 7));
    endtask

    initial begin
        bit pend0, pend1;
        int order;

        rst_n = 1'b0; clear_start = 0; clear_colour = 0;
        req0 = 0; x0 = 0; y0 = 0; c0 = 0;
        req1 = 0; x1 = 0; y1 = 0; c1 = 0;
        model_reset();
        #12;
        check_val("rst.plot", {31'b0, vga_plot}, 0);
        check_val("rst.busy", {31'b0, busy}, 0);
        check_val("rst.done", {31'b0, clear_done}, 0);
        check_val("rst.x", {24'b0, vga_x}, 0);
        check_val("rst.y", {25'b0, vga_y}, 0);
        check_val("rst.colour", {29'b0, vga_colour}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single pixel from requester 0
        req0 = 1; x0 = 10; y0 = 20; c0 = 3;
        step("single");
        check_val("single.gnt_seen", {31'b0, eg0}, 1);
        req0 = 0;
        step("single_out");
        step("single_idle");

        // Both requesters held: strict alternation starting with 0
        order = 0;
        req0 = 1; x0 = 1; y0 = 1; c0 = 1;
        req1 = 1; x1 = 2; y1 = 2; c1 = 2;
        for (int i = 0; i < 4; i++) begin
            step("rr");
            order = (order << 1) | (gnt1 ? 1 : 0);
            if (eg0) begin x0 = x0 + 8'd4; y0 = y0 + 7'd4; end
            if (eg1) begin x1 = x1 + 8'd4; y1 = y1 + 7'd4; end
        end
        check_val("rr.order", order, 32'b0101);
        req0 = 0; req1 = 0;
        step("rr_tail");
        step("rr_idle");

        // Out-of-range pixels are granted but not plotted
        req0 = 1; x0 = 8'd160; y0 = 7'd5; c0 = 7;
        step("oob_x");
        x0 = 8'd5; y0 = 7'd120;
        step("oob_y");
        x0 = 8'd159; y0 = 7'd119; c0 = 6;
        step("edge_px");
        req0 = 0;
        step("oob_out");
        step("oob_idle");

        // Randomised traffic
        pend0 = 0; pend1 = 0;
        for (int i = 0; i < 400; i++) begin
            if (!pend0 && $urandom_range(0, 3) != 0) begin new_pixel(x0, y0, c0); pend0 = 1; end
            if (!pend1 && $urandom_range(0, 3) != 0) begin new_pixel(x1, y1, c1); pend1 = 1; end
            req0 = pend0; req1 = pend1;
            step("rand");
            if (eg0) pend0 = 0;
            if (eg1) pend1 = 0;
        end
        req0 = 0; req1 = 0;
        step("rand_tail");
        step("rand_idle");

        // Full clear with requester 1 waiting and a stray second clear_start
        dut_plots = 0; dut_dones = 0; dut_g1 = 0;
        req1 = 1; x1 = 8'd1; y1 = 7'd2; c1 = 3'd4;
        clear_start = 1; clear_colour = 3'd5;
        step("clr_start");
        clear_start = 0;
        for (int i = 0; i < NPIX + 3; i++) begin
            if (i == 7000) begin clear_start = 1; clear_colour = 3'd2; end
            step("clr");
            clear_start = 0;
            if (eg1) req1 = 0;
        end
        check_val("clr.plots", dut_plots, NPIX + 1);
        check_val("clr.dones", dut_dones, 1);
        check_val("clr.gnt1_count", dut_g1, 1);

        // Reset partway through a sweep aborts it
        dut_dones = 0;
        clear_start = 1; clear_colour = 3'd6;
        step("abort_start");
        clear_start = 0;
        for (int i = 0; i < NPIX && m_n < 5000; i++) step("abort_run");
        check_val("abort.busy_before", {31'b0, busy}, 1);
        #2 rst_n = 1'b0;
        #1;
        check_val("abort.plot", {31'b0, vga_plot}, 0);
        check_val("abort.busy", {31'b0, busy}, 0);
        check_val("abort.done", {31'b0, clear_done}, 0);
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        step("post_rst_idle");
        req0 = 1; x0 = 8'd7; y0 = 7'd8; c0 = 3'd1;
        step("post_rst");
        req0 = 0;
        for (int i = 0; i < 4; i++) step("post_rst_out");
        check_val("abort.dones", dut_dones, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, got no finish expected finish");
        $fatal(1);
    end

endmodule
